// File: rtl/bus_reg_mux_pkg.sv
// Shared bus definitions: source index map and default bus geometry.
package bus_pkg;

  localparam int DEF_NSRC  = 24;
  localparam int DEF_WIDTH = 32;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_PC     = 16;
  localparam int SRC_MDR    = 17;
  localparam int SRC_INPORT = 18;
  localparam int SRC_HI     = 19;
  localparam int SRC_LO     = 20;
  localparam int SRC_ZHI    = 21;
  localparam int SRC_ZLO    = 22;
  localparam int SRC_C      = 23;

  // Source-ID width, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_reg_mux_if.sv
// Bus-side signal bundle: source words and selects in, bus views and
// conflict status out.
interface bus_reg_mux_if
  import bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSRC  = DEF_NSRC,
  parameter int CNT_W = 8
);

  localparam int IDW = id_width(NSRC);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_sel;
  logic                  err_clr;
  logic [WIDTH-1:0]      bus_comb;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [IDW-1:0]        bus_src;
  logic                  conflict;
  logic                  conflict_sticky;
  logic [CNT_W-1:0]      conflict_cnt;

  modport master (
    output src_data, src_sel, err_clr,
    input  bus_comb, bus_out, bus_valid, bus_src,
           conflict, conflict_sticky, conflict_cnt
  );

  modport slave (
    input  src_data, src_sel, err_clr,
    output bus_comb, bus_out, bus_valid, bus_src,
           conflict, conflict_sticky, conflict_cnt
  );

endinterface

// File: rtl/bus_reg_mux_onehot_prio_enc.sv
// Priority encoder for a one-hot-intended select vector: highest set
// bit index, any-set flag and more-than-one-set flag.
module onehot_prio_enc
  import bus_pkg::*;
#(
  parameter  int N  = DEF_NSRC,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  sel,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          multi
);

  if (N == 1) begin : g_single
    // A single source can never collide with another.
    always_comb begin
      idx   = '0;
      any   = sel[0];
      multi = 1'b0;
    end
  end else begin : g_multi
    // Ascending scan: the last hit is the highest index; a hit after an
    // earlier hit marks a collision.
    always_comb begin
      idx   = '0;
      any   = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (sel[i]) begin
          if (any) multi = 1'b1;
          any = 1'b1;
          idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bus_reg_mux.sv
// Shared bus multiplexer: highest-index-wins combinational bus, a
// registered bus stage with optional hold, source-ID readback and
// multi-driver conflict tracking.
module bus_reg_mux
  import bus_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NSRC    = DEF_NSRC,
  parameter int HOLD_EN = 1,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         clr,
  bus_reg_mux_if.slave bus
);

  localparam int IDW = id_width(NSRC);

  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic             w_multi;
  logic [WIDTH-1:0] w_bus_comb;

  logic [WIDTH-1:0] r_bus_out_p1;
  logic [IDW-1:0]   r_bus_src_p1;
  logic             r_vld_p1;
  logic             r_conflict_p1;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  // Saturating increment: the event counter parks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  onehot_prio_enc #(.N(NSRC)) u_enc (
    .sel   (bus.src_sel),
    .idx   (w_idx),
    .any   (w_any),
    .multi (w_multi)
  );

  // Last-assignment-wins mux; only selected words are ever read.
  always_comb begin
    w_bus_comb = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.src_sel[i]) w_bus_comb = bus.src_data[i*WIDTH +: WIDTH];
    end
  end

  // ---- stage p1: registered bus word, source ID and valid ----
  always_ff @(posedge clk) begin
    if (clr) begin
      r_bus_out_p1 <= '0;
      r_bus_src_p1 <= '0;
      r_vld_p1     <= 1'b0;
    end else if (w_any) begin
      r_bus_out_p1 <= w_bus_comb;
      r_bus_src_p1 <= w_idx;
      r_vld_p1     <= 1'b1;
    end else begin
      r_vld_p1 <= 1'b0;
      if (HOLD_EN == 0) begin
        r_bus_out_p1 <= '0;
        r_bus_src_p1 <= '0;
      end
    end
  end

  // Conflict pulse, sticky flag and counter; a fresh conflict beats err_clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_conflict_p1 <= 1'b0;
      r_sticky      <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_conflict_p1 <= w_multi;
      if (w_multi) begin
        r_sticky <= 1'b1;
        r_cnt    <= bus.err_clr ? CNT_W'(1) : sat_inc(r_cnt);
      end else if (bus.err_clr) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign bus.bus_comb        = w_bus_comb;
  assign bus.bus_out         = r_bus_out_p1;
  assign bus.bus_src         = r_bus_src_p1;
  assign bus.bus_valid       = r_vld_p1;
  assign bus.conflict        = r_conflict_p1;
  assign bus.conflict_sticky = r_sticky;
  assign bus.conflict_cnt    = r_cnt;

endmodule

// File: tb/tb_bus_reg_mux.sv
// Bench for bus_reg_mux: three instances (hold/8-bit counter,
// zero/4-bit counter, single 8-bit source) driven from one stimulus.
module tb_bus_reg_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [767:0] tb_data;
  logic [23:0]  tb_sel;
  logic         tb_err;
  logic         tb_clr;

  bus_reg_mux_if #(.WIDTH(32), .NSRC(24), .CNT_W(8)) ifa ();
  bus_reg_mux_if #(.WIDTH(32), .NSRC(24), .CNT_W(4)) ifb ();
  bus_reg_mux_if #(.WIDTH(8),  .NSRC(1),  .CNT_W(4)) ifc ();

  assign ifa.src_data = tb_data;
  assign ifa.src_sel  = tb_sel;
  assign ifa.err_clr  = tb_err;
  assign ifb.src_data = tb_data;
  assign ifb.src_sel  = tb_sel;
  assign ifb.err_clr  = tb_err;
  assign ifc.src_data = tb_data[7:0];
  assign ifc.src_sel  = tb_sel[0:0];
  assign ifc.err_clr  = tb_err;

  bus_reg_mux #(.WIDTH(32), .NSRC(24), .HOLD_EN(1), .CNT_W(8)) dut_a (.clk(clk), .clr(tb_clr), .bus(ifa));
  bus_reg_mux #(.WIDTH(32), .NSRC(24), .HOLD_EN(0), .CNT_W(4)) dut_b (.clk(clk), .clr(tb_clr), .bus(ifb));
  bus_reg_mux #(.WIDTH(8),  .NSRC(1),  .HOLD_EN(1), .CNT_W(4)) dut_c (.clk(clk), .clr(tb_clr), .bus(ifc));

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] out;
    int          src;
    bit          valid;
    bit          conf;
    bit          sticky;
    int          cnt;
  } mstate_t;

  mstate_t ma, mb, mc;

  typedef struct {
    logic [23:0] sel;
    bit          err;
    logic [31:0] comb;
    logic [31:0] a_out;
    int          a_src;
    logic [31:0] b_out;
    int          b_src;
    bit          valid;
    bit          conf;
    bit          sticky;
    int          cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner word of the first nsrc sources, or zero when none selected.
  function automatic logic [31:0] mcomb(input int nsrc, input logic [31:0] wmask,
                                        input logic [23:0] sel, input logic [767:0] data);
    for (int i = nsrc - 1; i >= 0; i--)
      if (sel[i]) return data[i*32 +: 32] & wmask;
    return 32'h0;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int nsrc, input logic [31:0] wmask,
                                    input bit hold, input int cmax, input logic [23:0] sel,
                                    input logic [767:0] data, input bit errc, input bit clrv);
    mstate_t ns;
    int nsel;
    int win;
    ns   = s;
    nsel = 0;
    win  = -1;
    for (int i = 0; i < nsrc; i++) nsel += sel[i] ? 1 : 0;
    for (int i = nsrc - 1; i >= 0; i--) if (sel[i] && win < 0) win = i;
    if (clrv) begin
      ns = '{out: 32'h0, src: 0, valid: 1'b0, conf: 1'b0, sticky: 1'b0, cnt: 0};
      return ns;
    end
    if (win >= 0) begin
      ns.out   = data[win*32 +: 32] & wmask;
      ns.src   = win;
      ns.valid = 1'b1;
    end else begin
      ns.valid = 1'b0;
      if (!hold) begin
        ns.out = 32'h0;
        ns.src = 0;
      end
    end
    ns.conf = (nsel >= 2);
    if (nsel >= 2) begin
      ns.sticky = 1'b1;
      ns.cnt    = errc ? 1 : ((s.cnt < cmax) ? s.cnt + 1 : s.cnt);
    end else if (errc) begin
      ns.sticky = 1'b0;
      ns.cnt    = 0;
    end
    return ns;
  endfunction

  task automatic check_models();
    chk("a_out",    64'(ifa.bus_out),         64'(ma.out));
    chk("a_src",    64'(ifa.bus_src),         64'(ma.src));
    chk("a_valid",  64'(ifa.bus_valid),       64'(ma.valid));
    chk("a_conf",   64'(ifa.conflict),        64'(ma.conf));
    chk("a_sticky", 64'(ifa.conflict_sticky), 64'(ma.sticky));
    chk("a_cnt",    64'(ifa.conflict_cnt),    64'(ma.cnt));
    chk("b_out",    64'(ifb.bus_out),         64'(mb.out));
    chk("b_src",    64'(ifb.bus_src),         64'(mb.src));
    chk("b_valid",  64'(ifb.bus_valid),       64'(mb.valid));
    chk("b_conf",   64'(ifb.conflict),        64'(mb.conf));
    chk("b_sticky", 64'(ifb.conflict_sticky), 64'(mb.sticky));
    chk("b_cnt",    64'(ifb.conflict_cnt),    64'(mb.cnt));
    chk("c_out",    64'(ifc.bus_out),         64'(mc.out));
    chk("c_src",    64'(ifc.bus_src),         64'(mc.src));
    chk("c_valid",  64'(ifc.bus_valid),       64'(mc.valid));
    chk("c_conf",   64'(ifc.conflict),        64'(mc.conf));
    chk("c_sticky", 64'(ifc.conflict_sticky), 64'(mc.sticky));
    chk("c_cnt",    64'(ifc.conflict_cnt),    64'(mc.cnt));
  endtask

  // One clock: apply at negedge, check comb, clock the models, check regs.
  task automatic cycle(input logic [23:0] sel, input bit errc, input bit clrv);
    tb_sel = sel;
    tb_err = errc;
    tb_clr = clrv;
    #1;
    chk("a_comb", 64'(ifa.bus_comb), 64'(mcomb(24, 32'hFFFF_FFFF, sel, tb_data)));
    chk("b_comb", 64'(ifb.bus_comb), 64'(mcomb(24, 32'hFFFF_FFFF, sel, tb_data)));
    chk("c_comb", 64'(ifc.bus_comb), 64'(mcomb(1, 32'h0000_00FF, sel, tb_data)));
    @(posedge clk);
    ma = mstep(ma, 24, 32'hFFFF_FFFF, 1'b1, 255, sel, tb_data, errc, clrv);
    mb = mstep(mb, 24, 32'hFFFF_FFFF, 1'b0, 15,  sel, tb_data, errc, clrv);
    mc = mstep(mc, 1,  32'h0000_00FF, 1'b1, 15,  sel, tb_data, errc, clrv);
    @(negedge clk);
    check_models();
  endtask

  task automatic check_ab(input string tag, input vec_t v);
    chk({tag, "_comb"},   64'(ifa.bus_comb),        64'(v.comb));
    chk({tag, "_a_out"},  64'(ifa.bus_out),         64'(v.a_out));
    chk({tag, "_a_src"},  64'(ifa.bus_src),         64'(v.a_src));
    chk({tag, "_b_out"},  64'(ifb.bus_out),         64'(v.b_out));
    chk({tag, "_b_src"},  64'(ifb.bus_src),         64'(v.b_src));
    chk({tag, "_valid"},  64'(ifa.bus_valid),       64'(v.valid));
    chk({tag, "_conf"},   64'(ifa.conflict),        64'(v.conf));
    chk({tag, "_sticky"}, 64'(ifa.conflict_sticky), 64'(v.sticky));
    chk({tag, "_cnt_a"},  64'(ifa.conflict_cnt),    64'(v.cnt));
    chk({tag, "_cnt_b"},  64'(ifb.conflict_cnt),    64'(v.cnt));
  endtask

  function automatic logic [23:0] rand_sel();
    int k;
    k = $urandom_range(9);
    if (k < 2) return 24'h0;
    if (k < 7) return 24'h1 << $urandom_range(23);
    return 24'($urandom) & 24'($urandom);
  endfunction

  initial begin
    logic [23:0] csel;
    ma = '{out: 32'h0, src: 0, valid: 1'b0, conf: 1'b0, sticky: 1'b0, cnt: 0};
    mb = ma;
    mc = ma;
    tb_sel = '0;
    tb_err = 1'b0;
    tb_clr = 1'b1;
    for (int i = 0; i < 24; i++) tb_data[i*32 +: 32] = $urandom;
    @(negedge clk);

    // Reset with random selects.
    cycle(rand_sel(), 1'b0, 1'b1);
    cycle(24'hC0_0101, 1'b1, 1'b1);
    chk("rst_out",    64'(ifa.bus_out),         64'h0);
    chk("rst_src",    64'(ifa.bus_src),         64'h0);
    chk("rst_valid",  64'(ifa.bus_valid),       64'h0);
    chk("rst_conf",   64'(ifa.conflict),        64'h0);
    chk("rst_sticky", 64'(ifa.conflict_sticky), 64'h0);
    chk("rst_cnt",    64'(ifa.conflict_cnt),    64'h0);

    // Fixed source words for the directed part.
    for (int i = 0; i < 24; i++) tb_data[i*32 +: 32] = 32'hA000_0000 | i;
    tb_data[0*32  +: 32] = 32'h0000_00C3;
    tb_data[3*32  +: 32] = 32'h0000_0011;
    tb_data[5*32  +: 32] = 32'hDEAD_BEEF;
    tb_data[16*32 +: 32] = 32'h0000_0A5C;
    tb_data[22*32 +: 32] = 32'h0000_0022;

    tbl[0] = '{24'h01_0000, 1'b0, 32'h0A5C, 32'h0A5C, 16, 32'h0A5C, 16, 1'b1, 1'b0, 1'b0, 0};
    tbl[1] = '{24'h40_0008, 1'b0, 32'h22, 32'h22, 22, 32'h22, 22, 1'b1, 1'b1, 1'b1, 1};
    tbl[2] = '{24'h00_0000, 1'b0, 32'h0, 32'h22, 22, 32'h0, 0, 1'b0, 1'b0, 1'b1, 1};
    tbl[3] = '{24'h00_0020, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 5, 32'hDEADBEEF, 5, 1'b1, 1'b0, 1'b1, 1};
    tbl[4] = '{24'h00_0000, 1'b0, 32'h0, 32'hDEADBEEF, 5, 32'h0, 0, 1'b0, 1'b0, 1'b1, 1};
    tbl[5] = '{24'h00_0000, 1'b0, 32'h0, 32'hDEADBEEF, 5, 32'h0, 0, 1'b0, 1'b0, 1'b1, 1};
    tbl[6] = '{24'h00_0000, 1'b0, 32'h0, 32'hDEADBEEF, 5, 32'h0, 0, 1'b0, 1'b0, 1'b1, 1};
    tbl[7] = '{24'h00_0000, 1'b1, 32'h0, 32'hDEADBEEF, 5, 32'h0, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[8] = '{24'h00_0003, 1'b1, 32'hA0000001, 32'hA0000001, 1, 32'hA0000001, 1, 1'b1, 1'b1, 1'b1, 1};
    tbl[9] = '{24'h00_0000, 1'b0, 32'h0, 32'hA0000001, 1, 32'h0, 0, 1'b0, 1'b0, 1'b1, 1};

    for (int r = 0; r < 10; r++) begin
      cycle(tbl[r].sel, tbl[r].err, 1'b0);
      check_ab($sformatf("tbl%0d", r), tbl[r]);
    end

    // Single-source instance: R0 low byte held, never a conflict.
    chk("c_hold_out", 64'(ifc.bus_out),         64'hC3);
    chk("c_no_stick", 64'(ifc.conflict_sticky), 64'h0);

    // Saturation: 20 conflict cycles.
    for (int i = 0; i < 20; i++) cycle(24'h80_0001, 1'b0, 1'b0);
    chk("sat_cnt_a", 64'(ifa.conflict_cnt),    64'd21);
    chk("sat_cnt_b", 64'(ifb.conflict_cnt),    64'd15);
    chk("sat_stk_b", 64'(ifb.conflict_sticky), 64'h1);
    chk("sat_src",   64'(ifa.bus_src),         64'd23);

    // err_clr alone.
    cycle(24'h0, 1'b1, 1'b0);
    chk("eclr_cnt_b", 64'(ifb.conflict_cnt),    64'h0);
    chk("eclr_stk_b", 64'(ifb.conflict_sticky), 64'h0);
    chk("eclr_cnt_a", 64'(ifa.conflict_cnt),    64'h0);
    chk("eclr_hold",  64'(ifa.bus_out),         64'hA000_0017);

    // err_clr together with a conflict: the event wins.
    cycle(24'h00_0014, 1'b1, 1'b0);
    chk("eboth_cnt", 64'(ifb.conflict_cnt),    64'h1);
    chk("eboth_stk", 64'(ifb.conflict_sticky), 64'h1);
    chk("eboth_src", 64'(ifa.bus_src),         64'd4);

    // clr in the middle of a conflict burst.
    for (int i = 0; i < 3; i++) cycle(24'h00_0014, 1'b0, 1'b0);
    chk("burst_cnt", 64'(ifa.conflict_cnt), 64'd4);
    cycle(24'h00_0014, 1'b0, 1'b1);
    chk("clr_comb",   64'(ifa.bus_comb),        64'hA000_0004);
    chk("clr_out",    64'(ifa.bus_out),         64'h0);
    chk("clr_conf",   64'(ifa.conflict),        64'h0);
    chk("clr_sticky", 64'(ifa.conflict_sticky), 64'h0);
    chk("clr_cnt",    64'(ifa.conflict_cnt),    64'h0);
    cycle(24'h0, 1'b0, 1'b0);
    chk("post_clr_hold",  64'(ifa.bus_out),   64'h0);
    chk("post_clr_valid", 64'(ifa.bus_valid), 64'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 24; i++) tb_data[i*32 +: 32] = $urandom;
      csel = rand_sel();
      cycle(csel, ($urandom_range(9) == 0), ($urandom_range(29) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bus_reg_mux.md
Name: bus_reg_mux

Overview:
Parametrised successor to the datapath bus multiplexer. It selects one of NSRC word sources onto the shared bus, with a fixed highest-index-wins priority. It adds a registered bus stage, an optional hold-last-value mode, a source-ID readback, and multi-driver conflict detection with a sticky flag and a saturating event counter. It sits between the register file / datapath registers and every bus consumer (MAR, Y, IR, register file, ALU).

Parameters:
WIDTH, 32, bus word width in bits
NSRC, 24, number of bus sources (R0-R15, PC, MDR, InPort, HI, LO, ZHI, ZLO, C)
HOLD_EN, 1, 1: registered bus holds its last value when no source is selected; 0: registered bus goes to zero
CNT_W, 8, width of conflict event counter
IDW, $clog2(NSRC), width of source-ID field (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
src_data  in  NSRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH]
src_sel  in  NSRC  per-source select, one-hot intended
err_clr  in  1  clears conflict_sticky and conflict_cnt
bus_comb  out  WIDTH  combinational bus value, same cycle as src_sel
bus_out  out  WIDTH  registered bus value
bus_valid  out  1  registered: some source was selected in the previous cycle
bus_src  out  IDW  registered index of the winning source
conflict  out  1  registered one-cycle pulse: more than one select was high in the previous cycle
conflict_sticky  out  1  set by any conflict, cleared only by err_clr or clr
conflict_cnt  out  CNT_W  count of conflict cycles, saturating

Behaviour:
- Winner = highest index i with src_sel[i]=1. No select: bus_comb = 0.
- bus_comb is purely combinational (zero latency). It preserves the legacy last-assignment-wins semantics.
- Registered path, one-cycle latency. At each rising clk edge without clr:
  - any select: bus_out <= winner data; bus_src <= winner index; bus_valid <= 1
  - no select, HOLD_EN=1: bus_out and bus_src unchanged; bus_valid <= 0
  - no select, HOLD_EN=0: bus_out <= 0; bus_src <= 0; bus_valid <= 0
- Conflict = popcount(src_sel) >= 2, evaluated each cycle.
  - conflict <= that condition each cycle.
  - conflict_sticky <= 1 when the condition holds.
  - conflict_cnt increments by 1 per conflict cycle, saturating at 2^CNT_W-1 (never wraps).
- err_clr without a same-cycle conflict: sticky <= 0, cnt <= 0.
- err_clr and conflict in the same cycle: the new event wins. sticky <= 1, cnt <= 1.
- clr has top priority over all other inputs. Next edge sets bus_out, bus_src, bus_valid, conflict, conflict_sticky and conflict_cnt to 0. bus_comb is unaffected by clr.
- clr asserted mid-stream: the cycle after clr deasserts behaves as a fresh start. With no select, HOLD_EN=1 holds 0.
- NSRC=1: IDW is forced to a minimum of 1, and conflict is tied to 0.
- No X propagation: unselected sources never reach either bus output.

Decomposition:
- Shared package bus_pkg holds:
  - source index constants: SRC_R0=0 .. SRC_R15=15, SRC_PC=16, SRC_MDR=17, SRC_INPORT=18, SRC_HI=19, SRC_LO=20, SRC_ZHI=21, SRC_ZLO=22, SRC_C=23
  - default NSRC=24 and WIDTH=32
- One sub-module, onehot_prio_enc (parameter N). Inputs: sel[N-1:0]. Outputs: idx (highest set bit), any, multi (popcount>=2). It is purely combinational and instantiated once.

Test Plan:
- Reset: clr=1 for 2 cycles with random selects -> all registered outputs 0; bus_comb follows selects.
- Single source: src_sel=1<<16 (PC), PC=0x0000_0A5C -> bus_comb=0x0A5C the same cycle; next edge bus_out=0x0A5C, bus_src=16, bus_valid=1, conflict=0.
- Priority and conflict: sel R3 (0x11) and ZLO (0x22) together -> bus_comb=0x22; next edge bus_src=22, conflict=1, sticky=1, cnt=1; sel cleared -> conflict=0, sticky stays 1.
- Hold vs zero: R5=0xDEAD_BEEF selected 1 cycle, then none for 3 cycles -> HOLD_EN=1: bus_out stays 0xDEADBEEF, bus_valid=0; HOLD_EN=0: bus_out=0, bus_src=0.
- Saturation: CNT_W=4, 20 consecutive conflict cycles -> cnt stops at 15; err_clr alone -> cnt=0, sticky=0.
- err_clr with a same-cycle conflict -> cnt=1, sticky=1. clr asserted during a conflict burst -> all registered outputs 0 the next cycle.
